// File: rtl/nbit_stream_demux_pkg.sv
// Shared types and constants for the registered stream demultiplexer.
package nbit_stream_demux_pkg;

   // Occupancy of a one-entry channel slot.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Width of the accepted-transaction counter; it wraps naturally.
   localparam int unsigned XFER_COUNT_WIDTH = 16;

   // Number of output channels addressed by a select of the given width.
   function automatic int unsigned num_out(input int unsigned select_width);
      return 32'd1 << select_width;
   endfunction

endpackage

// File: rtl/nbit_stream_demux_if.sv
// Bundle of the upstream handshake, per-channel outputs and the counter.
interface nbit_stream_demux_if
   import nbit_stream_demux_pkg::*;
#(
   parameter int unsigned SELECT_WIDTH = 4,
   parameter int unsigned DATA_WIDTH   = 32
);

   localparam int unsigned NUM_OUT = num_out(SELECT_WIDTH);

   logic                            InValid;
   logic                            InReady;
   logic [DATA_WIDTH-1:0]           InData;
   logic [SELECT_WIDTH-1:0]         InSel;
   logic                            InBcast;
   logic [NUM_OUT-1:0]              OutValid;
   logic [NUM_OUT-1:0]              OutReady;
   logic [NUM_OUT*DATA_WIDTH-1:0]   OutData;
   logic [XFER_COUNT_WIDTH-1:0]     XferCount;

   // Upstream producer together with the downstream consumers.
   modport master (
      output InValid,
      output InData,
      output InSel,
      output InBcast,
      output OutReady,
      input  InReady,
      input  OutValid,
      input  OutData,
      input  XferCount
   );

   // The demultiplexer itself.
   modport slave (
      input  InValid,
      input  InData,
      input  InSel,
      input  InBcast,
      input  OutReady,
      output InReady,
      output OutValid,
      output OutData,
      output XferCount
   );

endinterface

// File: rtl/nbit_stream_demux_slot.sv
// One-entry output buffer for a single demux channel. Free is asserted when
// the slot is empty or is being drained this cycle, so a load and a drain may
// coincide and the channel sustains one transfer per cycle.
module stream_demux_slot
   import nbit_stream_demux_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Load,
   input  logic [DATA_WIDTH-1:0] LoadData,
   input  logic                  Ready,
   output logic                  Valid,
   output logic [DATA_WIDTH-1:0] Data,
   output logic                  Free
);

   slot_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   // Next-state: fill on load, empty on drain unless refilled in the same cycle.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      unique case (state_q)
         SLOT_EMPTY: begin
            if (Load) begin
               state_d = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (Ready && !Load) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: begin
            state_d = SLOT_EMPTY;
         end
      endcase
      // Data is only overwritten by a load; it is left in place on drain.
      if (Load) begin
         data_d = LoadData;
      end
   end

   // State and payload registers, cleared asynchronously.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Outputs come straight from registers except Free, which looks at Ready.
   always_comb begin
      Valid = (state_q == SLOT_FULL);
      Data  = data_q;
      Free  = (state_q == SLOT_EMPTY) || Ready;
   end

endmodule

// File: rtl/nbit_stream_demux.sv
// Registered 1-to-2^SELECT_WIDTH stream demultiplexer. A unicast is taken
// when its target slot is free; a broadcast only when every slot is free, and
// then it loads all of them at once. Output data is always registered.
module nbit_stream_demux
   import nbit_stream_demux_pkg::*;
#(
   parameter int unsigned SELECT_WIDTH = 4,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                Clk,
   input  logic                Reset_n,
   nbit_stream_demux_if.slave  bus
);

   localparam int unsigned NUM_OUT = num_out(SELECT_WIDTH);

   logic [NUM_OUT-1:0]          free;
   logic [NUM_OUT-1:0]          load;
   logic                        in_ready;
   logic                        accept;
   logic [XFER_COUNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;

   // Acceptance and per-channel load strobes. InReady depends combinationally
   // on OutReady through Free; that path is deliberate.
   always_comb begin
      in_ready = bus.InBcast ? (&free) : free[bus.InSel];
      accept   = bus.InValid && in_ready;
      load     = '0;
      if (accept) begin
         if (bus.InBcast) begin
            load = '1;
         end else begin
            load[bus.InSel] = 1'b1;
         end
      end
   end

   // A broadcast counts as a single transaction.
   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (accept) begin
         xfer_cnt_d = xfer_cnt_q + XFER_COUNT_WIDTH'(1);
      end
   end

   // Accepted-transaction counter; wraps from all-ones back to zero.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         xfer_cnt_q <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   // Drive the upstream ready and the counter onto the interface.
   always_comb begin
      bus.InReady   = in_ready;
      bus.XferCount = xfer_cnt_q;
   end

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
      stream_demux_slot #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
         .Clk      (Clk),
         .Reset_n  (Reset_n),
         .Load     (load[i]),
         .LoadData (bus.InData),
         .Ready    (bus.OutReady[i]),
         .Valid    (bus.OutValid[i]),
         .Data     (bus.OutData[i*DATA_WIDTH +: DATA_WIDTH]),
         .Free     (free[i])
      );
   end

endmodule

// File: tb/tb_nbit_stream_demux.sv
// Testbench for nbit_stream_demux: directed cases plus random traffic, with a
// per-channel queue scoreboard and a monitor running on the falling edge.
module tb_nbit_stream_demux;

   localparam int unsigned SW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned NO = 16;

   logic Clk;
   logic Reset_n;

   nbit_stream_demux_if #(.SELECT_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

   nbit_stream_demux #(.SELECT_WIDTH(SW), .DATA_WIDTH(DW)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: each channel holds a queue of words still to be consumed.
   logic [DW-1:0] exp_q [NO][$];
   int unsigned   exp_cnt = 0;
   logic          model_ready = 1'b0;
   logic [NO-1:0] drain = '0;
   logic          acc_last = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Model update at the clock edge: retire consumed words, then accept.
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NO; i++) exp_q[i].delete();
         exp_cnt  <= 0;
         acc_last <= 1'b0;
      end else begin
         for (int i = 0; i < NO; i++) begin
            if (drain[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
         end
         acc_last <= bus.InValid && model_ready;
         if (bus.InValid && model_ready) begin
            exp_cnt <= (exp_cnt + 1) % 65536;
            for (int i = 0; i < NO; i++) begin
               if (bus.InBcast || (bus.InSel == SW'(i))) exp_q[i].push_back(bus.InData);
            end
         end
      end
   end

   // Monitor: compare what the DUT presents against the model each cycle.
   always @(negedge Clk) begin : mon
      logic [NO-1:0] fr;
      logic          er;
      if (Reset_n) begin
         for (int i = 0; i < NO; i++) begin
            fr[i] = (exp_q[i].size() == 0) || bus.OutReady[i];
            chk("out_valid", 64'(bus.OutValid[i]), 64'(exp_q[i].size() != 0));
            if (bus.OutValid[i] && exp_q[i].size() > 0)
               chk("out_data", 64'(bus.OutData[i*DW +: DW]), 64'(exp_q[i][0]));
         end
         er = bus.InBcast ? (&fr) : fr[bus.InSel];
         chk("in_ready", 64'(bus.InReady), 64'(er));
         chk("xfer_count", 64'(bus.XferCount), 64'(exp_cnt));
         model_ready <= er;
         drain       <= bus.OutReady;
      end
   end

   initial begin
      Reset_n      = 1'b0;
      bus.InValid  = 1'b0;
      bus.InData   = '0;
      bus.InSel    = '0;
      bus.InBcast  = 1'b0;
      bus.OutReady = '0;

      // Reset and idle with no consumer ready.
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_out_valid", 64'(bus.OutValid), 64'h0);
      chk("rst_out_data_nz", 64'(|bus.OutData), 64'h0);
      chk("rst_xfer_count", 64'(bus.XferCount), 64'h0);
      Reset_n = 1'b1;
      #1;
      chk("idle_in_ready", 64'(bus.InReady), 64'h1);
      bus.InBcast = 1'b1;
      #1;
      chk("idle_in_ready_bcast", 64'(bus.InReady), 64'h1);
      bus.InBcast = 1'b0;
      tick();

      // Unicast to channel 5 held four cycles with every consumer ready.
      bus.OutReady = '1;
      bus.InValid  = 1'b1;
      bus.InSel    = 4'h5;
      bus.InData   = 32'hA5A5_0001;
      tick();
      chk("uc5_valid_first", 64'(bus.OutValid), 64'h0020);
      repeat (3) tick();
      bus.InValid = 1'b0;
      #1;
      chk("uc5_count", 64'(bus.XferCount), 64'd4);
      chk("uc5_valid", 64'(bus.OutValid), 64'h0020);
      chk("uc5_data", 64'(bus.OutData[5*DW +: DW]), 64'hA5A5_0001);
      tick();

      // Channel 3 stalled: second beat must wait until the consumer is ready.
      bus.OutReady = '0;
      bus.InValid  = 1'b1;
      bus.InSel    = 4'h3;
      bus.InData   = 32'h1;
      tick();
      bus.InData = 32'h2;
      #1;
      chk("ch3_blocked_ready", 64'(bus.InReady), 64'h0);
      tick();
      chk("ch3_hold_data", 64'(bus.OutData[3*DW +: DW]), 64'h1);
      chk("ch3_hold_count", 64'(bus.XferCount), 64'd5);
      bus.OutReady = 16'h0008;
      #1;
      chk("ch3_release_ready", 64'(bus.InReady), 64'h1);
      tick();
      bus.InValid = 1'b0;
      #1;
      chk("ch3_new_data", 64'(bus.OutData[3*DW +: DW]), 64'h2);
      chk("ch3_valid", 64'(bus.OutValid[3]), 64'h1);
      chk("ch3_count", 64'(bus.XferCount), 64'd6);

      // Broadcast blocked by a full, stalled channel 9.
      bus.OutReady = ~16'h0200;
      bus.InValid  = 1'b1;
      bus.InSel    = 4'h9;
      bus.InData   = 32'h99;
      tick();
      bus.InBcast = 1'b1;
      bus.InData  = 32'hDEAD_BEEF;
      #1;
      chk("bc_blocked_ready", 64'(bus.InReady), 64'h0);
      tick();
      chk("bc_blocked_valid", 64'(bus.OutValid), 64'h0200);
      chk("bc_blocked_count", 64'(bus.XferCount), 64'd7);
      bus.OutReady = '1;
      #1;
      chk("bc_release_ready", 64'(bus.InReady), 64'h1);
      tick();
      bus.InValid = 1'b0;
      bus.InBcast = 1'b0;
      #1;
      chk("bc_all_valid", 64'(bus.OutValid), 64'hFFFF);
      for (int i = 0; i < NO; i++) chk("bc_data", 64'(bus.OutData[i*DW +: DW]), 64'hDEAD_BEEF);
      chk("bc_count", 64'(bus.XferCount), 64'd8);
      tick();

      // Random traffic; upstream holds its offer until it is accepted.
      for (int n = 0; n < 2000; n++) begin
         if (!(bus.InValid && !acc_last)) begin
            bus.InValid = ($urandom_range(0, 3) != 0);
            bus.InBcast = ($urandom_range(0, 7) == 0);
            bus.InSel   = SW'($urandom_range(0, NO - 1));
            bus.InData  = $urandom;
         end
         bus.OutReady = NO'($urandom) | NO'($urandom);
         tick();
      end
      bus.InValid  = 1'b0;
      bus.InBcast  = 1'b0;
      bus.OutReady = '1;
      repeat (2) tick();

      // Fill three slots, then reset between edges.
      bus.OutReady = '0;
      bus.InValid  = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         bus.InSel  = SW'(c);
         bus.InData = 32'hC0DE_0000 | c;
         tick();
      end
      bus.InValid = 1'b0;
      #1;
      chk("pre_rst_valid", 64'(bus.OutValid), 64'h000E);
      #1;
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.OutValid), 64'h0);
      chk("mid_rst_data_nz", 64'(|bus.OutData), 64'h0);
      chk("mid_rst_count", 64'(bus.XferCount), 64'h0);
      chk("mid_rst_in_ready", 64'(bus.InReady), 64'h1);
      tick();
      Reset_n = 1'b1;

      // Counter wrap: 65535 accepts reach all-ones, one more returns to zero.
      bus.OutReady = '1;
      bus.InValid  = 1'b1;
      bus.InBcast  = 1'b0;
      for (int n = 0; n < 65535; n++) begin
         bus.InSel  = SW'($urandom_range(0, NO - 1));
         bus.InData = $urandom;
         tick();
      end
      chk("wrap_ffff", 64'(bus.XferCount), 64'hFFFF);
      tick();
      chk("wrap_zero", 64'(bus.XferCount), 64'h0);
      bus.InValid = 1'b0;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nbit_stream_demux.md
# nbit_stream_demux

Registered, parametrised 1-to-2^SELECT_WIDTH stream demultiplexer with valid/ready flow control on every port. It is the clocked successor to the combinational n-bit demux. It routes a DATA_WIDTH payload either to one selected channel (unicast) or to all channels at once (broadcast). It sits between the multicycle control/datapath and its per-unit consumers, where consumers may stall independently.

## Interface
- SELECT_WIDTH, default 4: select width; NUM_OUT = 2**SELECT_WIDTH derived channels.
- DATA_WIDTH, default 32: payload width.
- Clk  in  1  sole clock, rising edge.
- Reset_n  in  1  reset; asynchronous assert, active-low.
- InValid  in  1  upstream offers a transaction.
- InReady  out  1  transaction accepted this cycle when InValid & InReady.
- InData  in  DATA_WIDTH  payload.
- InSel  in  SELECT_WIDTH  destination channel; ignored when InBcast=1.
- InBcast  in  1  deliver to all NUM_OUT channels.
- OutValid  out  NUM_OUT  per-channel data valid.
- OutReady  in  NUM_OUT  per-channel consumer ready.
- OutData  out  NUM_OUT*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- XferCount  out  16  accepted-transaction counter.

## Operation
- Each channel has a one-entry slot with states SLOT_EMPTY and SLOT_FULL. OutValid[i] = (state == SLOT_FULL).
- free[i] = !OutValid[i] | OutReady[i]. A slot draining this cycle counts as free, so each channel sustains 1 transfer/cycle.
- Unicast accept: InValid & !InBcast & free[InSel].
- Broadcast accept: InValid & InBcast & (&free). Broadcast is all-or-nothing; there are no partial deliveries.
- InReady = InBcast ? &free : free[InSel]. It is combinational from OutReady, InSel and InBcast; this path is intended.
- Slot transitions per channel i:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on OutReady[i] without load.
  - FULL -> FULL on OutReady[i] with simultaneous load; the new data replaces the old.
  - FULL holds while OutReady[i]=0.
- On load, OutData[i] takes InData. It is not cleared on drain; it holds its last value.
- While OutValid[i]=1 & OutReady[i]=0, OutValid[i] and OutData[i] stay stable.
- Upstream holds InData/InSel/InBcast stable while InValid & !InReady. The block does not check this.
- XferCount increments by 1 per accepted transaction (a broadcast counts as 1) and wraps 0xFFFF -> 0x0000.

## Timing
- Reset (Reset_n=0, asynchronous): all slots SLOT_EMPTY, OutValid=0, OutData=0, XferCount=0. InReady is therefore 1 for any InSel/InBcast.
- Reset mid-operation: buffered data is discarded immediately. The first accept is possible on the first rising edge after deassertion.
- Latency: a transaction accepted at edge N appears as OutValid/OutData after edge N. Visible in cycle N+1, with no combinational In->Out data path.
- Throughput: 1 transaction/cycle when the target consumers are continuously ready. A stalled channel blocks only unicasts to itself and all broadcasts.
- Simultaneous events: a load and drain on the same channel in one cycle leaves the slot FULL with the new data. Drains on other channels are independent.

## Structure
- Package nbit_stream_demux_pkg:
  - slot state enum {SLOT_EMPTY, SLOT_FULL};
  - XFER_COUNT_WIDTH = 16;
  - helper function num_out(select_width) = 2**select_width.
- Sub-module stream_demux_slot: one-entry buffer.
  - Ports: Clk, Reset_n, Load, LoadData, Ready, Valid, Data, Free.
  - Instantiated NUM_OUT times in a generate loop.
- The top level holds accept logic, InReady and XferCount.

## Test plan
Defaults throughout: SELECT_WIDTH=4, DATA_WIDTH=32.
- Reset, then idle with all OutReady=0 -> OutValid=16'h0000, XferCount=0, InReady=1.
- Unicast InSel=4'h5, InData=32'hA5A5_0001, OutReady=16'hFFFF, held 4 cycles -> OutValid[5] high from the cycle after the first accept, XferCount=4, no other channel valid.
- Unicast to channel 3 with OutReady[3]=0:
  - first beat 32'h1 fills the slot;
  - second beat 32'h2 sees InReady=0, and OutData[3] stays 32'h1;
  - raise OutReady[3] -> beat 2 is accepted the same cycle, and OutData[3]=32'h2 next cycle.
- Broadcast 32'hDEAD_BEEF with OutReady=16'hFFFF except channel 9 low and channel 9 FULL:
  - InReady=0 and no channel is loaded;
  - release channel 9 -> all 16 OutValid set next cycle with identical data, XferCount +1.
- Preload XferCount to 0xFFFF via 65535 accepts, one more accept -> XferCount=0.
- Pulse Reset_n low mid-stream with 3 slots FULL -> OutValid=0, OutData=0 immediately, before the next edge.
